uart_tx_slave: RTL and testbench

MemoryBus responder that replaces the tied-off UART window (base word 'h100, 4 words) with a real 8N1 serial transmitter. It accepts byte writes from the bus master (CPU or probe, after the master/slave muxes), buffers one byte in a holding register behind the shift register, and drives a serial `tx` line. Status and baud divisor are bus-readable, so firmware can poll rather than rely on a fixed delay.

---
 rtl/uart_tx_slave_pkg.sv | 32 +++
 rtl/uart_tx_slave_if.sv | 10 +
 rtl/uart_tx_slave_baud_gen.sv | 29 ++
 rtl/uart_tx_slave.sv | 173 +++++++++++++++++
 tb/tb_uart_tx_slave.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_slave_pkg.sv
// Bus transaction types shared with the rest of the SoC, plus the UART window's
// register map, status bit positions and FSM state encodings.
package MemoryBus;
    typedef struct packed {
        logic        mem_read;
        logic [3:0]  mask_byte;
        logic [31:0] write_data;
        logic        start;
    } Cmd;

    typedef struct packed {
        logic [31:0] data;
        logic        done;
    } Result;
endpackage

package uart_pkg;
    localparam logic [1:0] REG_TXDATA   = 2'd0;
    localparam logic [1:0] REG_STATUS   = 2'd1;
    localparam logic [1:0] REG_BAUD_DIV = 2'd2;

    localparam int STAT_SHIFTING  = 0;
    localparam int STAT_HOLD_FULL = 1;

    typedef enum logic [1:0] {B_IDLE, B_STALL, B_RESP} bus_state_e;
    typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_e;

    // A programmed divisor of 0 behaves as 1 cycle per bit.
    function automatic logic [15:0] eff_div(input logic [15:0] div);
        return (div == 16'd0) ? 16'd1 : div;
    endfunction
endpackage

// File: rtl/uart_tx_slave_if.sv
// MemoryBus window signals between the bus muxes and the UART responder.
interface uart_tx_slave_if;
    logic [1:0]       address;
    logic             write_enable;
    MemoryBus::Cmd    cmd;
    MemoryBus::Result result;

    modport master (output address, write_enable, cmd, input result);
    modport slave  (input address, write_enable, cmd, output result);
endinterface

// File: rtl/uart_tx_slave_baud_gen.sv
// Bit-period timer: counts div-1 down to 0 and pulses tick on the last cycle
// of each bit; restart holds it at the top of a fresh period.
module uart_baud_gen (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        restart_i,
    input  logic [15:0] div_i,
    output logic        tick_o
);
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d  = cnt_q;
        tick_o = 1'b0;
        if (restart_i) begin
            cnt_d = div_i - 16'd1;
        end else if (cnt_q == 16'd0) begin
            tick_o = 1'b1;
            cnt_d  = div_i - 16'd1;
        end else begin
            cnt_d = cnt_q - 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/uart_tx_slave.sv
// 8N1 UART transmitter behind the MemoryBus UART window: one holding byte in
// front of the shifter, stalled writes when it is full, pollable status/divisor.
module uart_tx_slave
    import uart_pkg::*;
#(
    parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
    input  logic            clk,
    input  logic            rst_n,
    uart_tx_slave_if.slave  bus,
    output logic            tx,
    output logic            tx_busy
);
    bus_state_e  bstate_q, bstate_d;
    tx_state_e   tstate_q, tstate_d;
    logic [31:0] rdata_q, rdata_d;
    logic [15:0] div_q, div_d;
    logic        hold_full_q, hold_full_d;
    logic        tx_q, tx_d;
    logic [7:0]  hold_q, hold_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bitcnt_q, bitcnt_d;
    logic        set_hold, consume, wr_tx, tick, shifting;
    logic [31:0] status;
    logic        unused_bits;

    assign unused_bits = ^{bus.cmd.mem_read, bus.cmd.mask_byte[3:2], bus.cmd.write_data[31:16]};

    assign shifting = (tstate_q != T_IDLE);
    assign wr_tx    = bus.write_enable && (bus.address == REG_TXDATA) && bus.cmd.mask_byte[0];

    always_comb begin
        status                 = '0;
        status[STAT_SHIFTING]  = shifting;
        status[STAT_HOLD_FULL] = hold_full_q;
    end

    uart_baud_gen u_baud (
        .clk       (clk),
        .rst_n     (rst_n),
        .restart_i (tstate_q == T_IDLE),
        .div_i     (eff_div(div_q)),
        .tick_o    (tick)
    );

    // Bus side: decode, register writes, read mux, stall on a full holding byte.
    always_comb begin
        bstate_d = bstate_q;
        rdata_d  = rdata_q;
        div_d    = div_q;
        hold_d   = hold_q;
        set_hold = 1'b0;
        case (bstate_q)
            B_IDLE: begin
                if (bus.cmd.start) begin
                    rdata_d = '0;
                    if (wr_tx && hold_full_q) begin
                        bstate_d = B_STALL;
                    end else begin
                        bstate_d = B_RESP;
                        if (wr_tx) begin
                            hold_d   = bus.cmd.write_data[7:0];
                            set_hold = 1'b1;
                        end else if (bus.write_enable) begin
                            if (bus.address == REG_BAUD_DIV) begin
                                if (bus.cmd.mask_byte[0]) div_d[7:0]  = bus.cmd.write_data[7:0];
                                if (bus.cmd.mask_byte[1]) div_d[15:8] = bus.cmd.write_data[15:8];
                            end
                        end else begin
                            case (bus.address)
                                REG_STATUS:   rdata_d = status;
                                REG_BAUD_DIV: rdata_d = {16'b0, div_q};
                                default:      rdata_d = '0;
                            endcase
                        end
                    end
                end
            end
            B_STALL: begin
                if (!hold_full_q) begin
                    hold_d   = bus.cmd.write_data[7:0];
                    set_hold = 1'b1;
                    bstate_d = B_RESP;
                end
            end
            B_RESP:  bstate_d = B_IDLE;
            default: bstate_d = B_IDLE;
        endcase
    end

    // Serial side: start, 8 data bits LSB first, stop; reload straight from
    // the holding byte at the end of a stop bit so frames are contiguous.
    always_comb begin
        tstate_d = tstate_q;
        shift_d  = shift_q;
        bitcnt_d = bitcnt_q;
        consume  = 1'b0;
        case (tstate_q)
            T_IDLE: begin
                if (hold_full_q) begin
                    consume  = 1'b1;
                    shift_d  = hold_q;
                    tstate_d = T_START;
                end
            end
            T_START: begin
                if (tick) begin
                    tstate_d = T_DATA;
                    bitcnt_d = 3'd0;
                end
            end
            T_DATA: begin
                if (tick) begin
                    if (bitcnt_q == 3'd7) begin
                        tstate_d = T_STOP;
                    end else begin
                        bitcnt_d = bitcnt_q + 3'd1;
                        shift_d  = {1'b0, shift_q[7:1]};
                    end
                end
            end
            T_STOP: begin
                if (tick) begin
                    if (hold_full_q) begin
                        consume  = 1'b1;
                        shift_d  = hold_q;
                        tstate_d = T_START;
                    end else begin
                        tstate_d = T_IDLE;
                    end
                end
            end
            default: tstate_d = T_IDLE;
        endcase

        case (tstate_d)
            T_START: tx_d = 1'b0;
            T_DATA:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    // Setting and consuming never coincide: set needs empty, consume needs full.
    assign hold_full_d = (hold_full_q & ~consume) | set_hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bstate_q    <= B_IDLE;
            tstate_q    <= T_IDLE;
            rdata_q     <= '0;
            div_q       <= DEFAULT_DIV;
            hold_full_q <= 1'b0;
            tx_q        <= 1'b1;
        end else begin
            bstate_q    <= bstate_d;
            tstate_q    <= tstate_d;
            rdata_q     <= rdata_d;
            div_q       <= div_d;
            hold_full_q <= hold_full_d;
            tx_q        <= tx_d;
        end
    end

    always_ff @(posedge clk) begin
        hold_q   <= hold_d;
        shift_q  <= shift_d;
        bitcnt_q <= bitcnt_d;
    end

    assign bus.result = {rdata_q, (bstate_q == B_RESP)};
    assign tx         = tx_q;
    assign tx_busy    = shifting | hold_full_q;
endmodule

// File: tb/tb_uart_tx_slave.sv
// Bench for uart_tx_slave: bus driver, a line-level 8N1 receiver model and
// scenario tasks comparing decoded frames and register reads with expectations.
module tb_uart_tx_slave;
    localparam logic [1:0] A_TXDATA = 2'd0;
    localparam logic [1:0] A_STATUS = 2'd1;
    localparam logic [1:0] A_BAUD   = 2'd2;

    logic clk = 1'b0;
    logic rst_n;
    logic tx, tx_busy;
    int   cyc = 0;
    int   checks = 0;
    int   passed = 0;
    int   mon_div = 868;
    int   rst_epoch = 0;

    logic [7:0] rx_byte[$];
    int         rx_start[$];
    logic       rx_stop[$];
    logic [7:0] exp_q[$];

    uart_tx_slave_if bus ();

    uart_tx_slave #(.DEFAULT_DIV(16'd868)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .tx      (tx),
        .tx_busy (tx_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Receiver model: sample mid-bit at the expected bit period.
    initial begin
        int ep, st, d;
        logic [7:0] b;
        logic sb;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx === 1'b0) begin
                ep = rst_epoch; st = cyc; d = mon_div; b = '0;
                repeat (d / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (d) @(negedge clk);
                    b[i] = tx;
                end
                repeat (d) @(negedge clk);
                sb = tx;
                if (ep == rst_epoch) begin
                    rx_byte.push_back(b);
                    rx_start.push_back(st);
                    rx_stop.push_back(sb);
                end
            end
        end
    end

    task automatic bus_xact(input logic we, input logic [1:0] addr, input logic [31:0] wd,
                            input logic [3:0] mask, input int budget,
                            output logic [31:0] rd, output int lat);
        bus.write_enable   = we;
        bus.address        = addr;
        bus.cmd.mem_read   = ~we;
        bus.cmd.mask_byte  = mask;
        bus.cmd.write_data = wd;
        bus.cmd.start      = 1'b1;
        @(negedge clk);
        bus.cmd.start = 1'b0;
        lat = 1;
        while (bus.result.done !== 1'b1 && lat < budget) begin
            @(negedge clk);
            lat++;
        end
        rd = bus.result.data;
        if (bus.result.done !== 1'b1) lat = -1;
        @(negedge clk);
        bus.write_enable = 1'b0;
        bus.cmd          = '0;
    endtask

    task automatic wait_idle(input int budget, output int tend, output bit ok);
        int n = 0;
        while (tx_busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        ok = (tx_busy === 1'b0);
        tend = cyc;
        repeat (2) @(negedge clk);
    endtask

    task automatic clear_rx();
        rx_byte.delete(); rx_start.delete(); rx_stop.delete(); exp_q.delete();
    endtask

    task automatic test_reset();
        logic [31:0] rd; int lat;
        checks++; if (tx !== 1'b1) $display("FAIL reset_tx: got %b want 1", tx); else passed++;
        checks++; if (tx_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", tx_busy); else passed++;
        checks++; if (bus.result.done !== 1'b0) $display("FAIL reset_done: got %b want 0", bus.result.done); else passed++;
        checks++; if (bus.result.data !== 32'h0) $display("FAIL reset_data: got %h want 0", bus.result.data); else passed++;
        bus_xact(1'b0, A_BAUD, 32'h0, 4'hF, 5, rd, lat);
        checks++; if (lat !== 1 || rd !== 32'd868) $display("FAIL reset_baud: got %h lat %0d want %h lat 1", rd, lat, 32'd868); else passed++;
        checks++; if (bus.result.done !== 1'b0) $display("FAIL done_pulse: got %b want 0", bus.result.done); else passed++;
        bus_xact(1'b0, A_STATUS, 32'h0, 4'hF, 5, rd, lat);
        checks++; if (lat !== 1 || rd !== 32'h0) $display("FAIL idle_status: got %h lat %0d want 0 lat 1", rd, lat); else passed++;
    endtask

    task automatic test_default_frame();
        logic [31:0] rd; int lat, tend; bit ok;
        clear_rx(); mon_div = 868;
        bus_xact(1'b1, A_TXDATA, 32'hDEAD_BE55, 4'b0001, 5, rd, lat);
        checks++; if (lat !== 1) $display("FAIL write55_lat: got %0d want 1", lat); else passed++;
        wait_idle(10 * 868 + 50, tend, ok);
        checks++; if (!ok) $display("FAIL frame55_timeout: busy %b want 0", tx_busy); else passed++;
        checks++; if (rx_byte.size() !== 1) $display("FAIL frame55_count: got %0d want 1", rx_byte.size());
        else begin
            passed++;
            checks++; if (rx_byte[0] !== 8'h55 || rx_stop[0] !== 1'b1) $display("FAIL frame55_data: got %h stop %b want 55 stop 1", rx_byte[0], rx_stop[0]); else passed++;
            checks++; if (tend - rx_start[0] !== 10 * 868) $display("FAIL frame55_len: got %0d want %0d", tend - rx_start[0], 10 * 868); else passed++;
        end
    endtask

    task automatic test_baud_mask();
        logic [31:0] rd; int lat;
        bus_xact(1'b1, A_BAUD, 32'h1234, 4'b0001, 5, rd, lat);
        bus_xact(1'b0, A_BAUD, 32'h0, 4'hF, 5, rd, lat);
        checks++; if (rd !== 32'h0334) $display("FAIL baud_low_mask: got %h want 00000334", rd); else passed++;
        bus_xact(1'b1, A_BAUD, 32'hFF12_34FF, 4'b0010, 5, rd, lat);
        bus_xact(1'b0, A_BAUD, 32'h0, 4'hF, 5, rd, lat);
        checks++; if (rd !== 32'h3434) $display("FAIL baud_high_mask: got %h want 00003434", rd); else passed++;
        bus_xact(1'b1, A_STATUS, 32'hFFFF_FFFF, 4'hF, 5, rd, lat);
        checks++; if (lat !== 1 || tx_busy !== 1'b0) $display("FAIL status_write: lat %0d busy %b want 1 0", lat, tx_busy); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; int lat, tend; bit ok;
        clear_rx(); mon_div = 4;
        bus_xact(1'b1, A_BAUD, 32'h4, 4'b0011, 5, rd, lat);
        bus_xact(1'b1, A_TXDATA, 32'hA3, 4'b0001, 5, rd, lat); exp_q.push_back(8'hA3);
        checks++; if (lat !== 1) $display("FAIL wA3_lat: got %0d want 1", lat); else passed++;
        bus_xact(1'b0, A_STATUS, 32'h0, 4'hF, 5, rd, lat);
        checks++; if (rd !== 32'h1) $display("FAIL status_shifting: got %h want 1", rd); else passed++;
        bus_xact(1'b1, A_TXDATA, 32'h0F, 4'b0001, 5, rd, lat); exp_q.push_back(8'h0F);
        checks++; if (lat !== 1) $display("FAIL w0F_nostall: got %0d want 1", lat); else passed++;
        bus_xact(1'b0, A_STATUS, 32'h0, 4'hF, 5, rd, lat);
        checks++; if (rd !== 32'h3) $display("FAIL status_holdfull: got %h want 3", rd); else passed++;
        bus_xact(1'b1, A_TXDATA, 32'h81, 4'b0001, 100, rd, lat); exp_q.push_back(8'h81);
        checks++; if (lat < 25 || lat > 45) $display("FAIL w81_stall: got %0d want 25..45", lat); else passed++;
        wait_idle(200, tend, ok);
        checks++; if (!ok || rx_byte.size() !== 3) $display("FAIL b2b_count: got %0d want 3", rx_byte.size());
        else begin
            passed++;
            for (int i = 0; i < 3; i++) begin
                checks++; if (rx_byte[i] !== exp_q[i] || rx_stop[i] !== 1'b1) $display("FAIL b2b_byte%0d: got %h want %h", i, rx_byte[i], exp_q[i]); else passed++;
            end
            for (int i = 0; i < 2; i++) begin
                checks++; if (rx_start[i+1] - rx_start[i] !== 40) $display("FAIL b2b_gap%0d: got %0d want 40", i, rx_start[i+1] - rx_start[i]); else passed++;
            end
        end
    endtask

    task automatic test_div_zero();
        logic [31:0] rd; int lat, tend; bit ok;
        clear_rx(); mon_div = 1;
        bus_xact(1'b1, A_BAUD, 32'h0, 4'b0011, 5, rd, lat);
        bus_xact(1'b0, A_BAUD, 32'h0, 4'hF, 5, rd, lat);
        checks++; if (rd !== 32'h0) $display("FAIL div0_read: got %h want 0", rd); else passed++;
        bus_xact(1'b1, A_TXDATA, 32'hFF, 4'b0001, 5, rd, lat);
        wait_idle(50, tend, ok);
        checks++; if (!ok || rx_byte.size() !== 1) $display("FAIL div0_count: got %0d want 1", rx_byte.size());
        else begin
            passed++;
            checks++; if (rx_byte[0] !== 8'hFF || tend - rx_start[0] !== 10) $display("FAIL div0_frame: got %h len %0d want ff len 10", rx_byte[0], tend - rx_start[0]); else passed++;
        end
    endtask

    task automatic test_masked_write();
        logic [31:0] rd; int lat; bit quiet = 1'b1;
        clear_rx();
        bus_xact(1'b1, A_TXDATA, 32'h5A, 4'b1110, 5, rd, lat);
        checks++; if (lat !== 1) $display("FAIL masked_lat: got %0d want 1", lat); else passed++;
        repeat (40) begin
            @(negedge clk);
            if (tx !== 1'b1 || tx_busy !== 1'b0) quiet = 1'b0;
        end
        checks++; if (!quiet || rx_byte.size() !== 0) $display("FAIL masked_noframe: frames %0d quiet %b want 0 1", rx_byte.size(), quiet); else passed++;
    endtask

    task automatic test_random();
        logic [31:0] rd, wd; int lat, tend, d; bit ok;
        clear_rx();
        d = $urandom_range(1, 5); mon_div = d;
        bus_xact(1'b1, A_BAUD, d, 4'b0011, 5, rd, lat);
        for (int i = 0; i < 6; i++) begin
            wd = $urandom;
            bus_xact(1'b1, A_TXDATA, wd, 4'b0001, 20 * d + 20, rd, lat);
            exp_q.push_back(wd[7:0]);
            checks++; if (lat < 1) $display("FAIL rand_wr%0d: timed out, done %b want 1", i, bus.result.done); else passed++;
        end
        wait_idle(20 * d * 8 + 50, tend, ok);
        checks++; if (!ok || rx_byte.size() !== 6) $display("FAIL rand_count: got %0d want 6 (div %0d)", rx_byte.size(), d);
        else begin
            passed++;
            for (int i = 0; i < 6; i++) begin
                checks++; if (rx_byte[i] !== exp_q[i] || rx_stop[i] !== 1'b1) $display("FAIL rand_byte%0d: got %h want %h", i, rx_byte[i], exp_q[i]); else passed++;
            end
            for (int i = 0; i < 5; i++) begin
                checks++; if (rx_start[i+1] - rx_start[i] !== 10 * d) $display("FAIL rand_gap%0d: got %0d want %0d", i, rx_start[i+1] - rx_start[i], 10 * d); else passed++;
            end
        end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] rd; logic [7:0] b; int lat, n; bit quiet = 1'b1;
        clear_rx(); mon_div = 8;
        bus_xact(1'b1, A_BAUD, 32'h8, 4'b0011, 5, rd, lat);
        b = 8'($urandom) & 8'hFB;
        bus_xact(1'b1, A_TXDATA, {24'h0, b}, 4'b0001, 5, rd, lat);
        n = 0;
        while (tx !== 1'b0 && n < 20) begin @(negedge clk); n++; end
        checks++; if (tx !== 1'b0) $display("FAIL rst_startbit: got %b want 0", tx); else passed++;
        repeat (3 * 8 + 3) @(negedge clk);
        checks++; if (tx !== 1'b0) $display("FAIL rst_bit2: got %b want 0", tx); else passed++;
        #2 rst_n = 1'b0; rst_epoch++;
        #1;
        checks++; if (tx !== 1'b1 || tx_busy !== 1'b0) $display("FAIL rst_async: tx %b busy %b want 1 0", tx, tx_busy); else passed++;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus_xact(1'b0, A_STATUS, 32'h0, 4'hF, 5, rd, lat);
        checks++; if (rd !== 32'h0) $display("FAIL rst_status: got %h want 0", rd); else passed++;
        bus_xact(1'b0, A_BAUD, 32'h0, 4'hF, 5, rd, lat);
        checks++; if (rd !== 32'd868) $display("FAIL rst_div: got %h want %h", rd, 32'd868); else passed++;
        repeat (150) begin
            @(negedge clk);
            if (tx !== 1'b1 || tx_busy !== 1'b0) quiet = 1'b0;
        end
        checks++; if (!quiet || rx_byte.size() !== 0) $display("FAIL rst_residual: frames %0d quiet %b want 0 1", rx_byte.size(), quiet); else passed++;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.write_enable = 1'b0;
        bus.address      = 2'd0;
        bus.cmd          = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_default_frame();
        test_baud_mask();
        test_back_to_back();
        test_div_zero();
        test_masked_write();
        test_random();
        test_reset_midframe();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
